// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, standard or FWFT read mode and optional sticky errors (FIFO_ERR_FLAGS_EN).

module fifo_sync_param_cfg_chk #(
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2
) ();
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if ((AFULL_THRESH < 0) || (AFULL_THRESH > DEPTH)) begin : g_bad_afull
        $error("fifo_sync_param: AFULL_THRESH outside 0..DEPTH");
    end
    if ((AEMPTY_THRESH < 0) || (AEMPTY_THRESH > DEPTH)) begin : g_bad_aempty
        $error("fifo_sync_param: AEMPTY_THRESH outside 0..DEPTH");
    end
endmodule

module fifo_sync_param #(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_we,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_re,
    input  logic                     i_err_clr,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_almost_full,
    output logic                     o_almost_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overflow,
    output logic                     o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_L  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_L  = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_L = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] ONE_L    = CW'(1);
    localparam logic [CW-1:0] ZERO_L   = {CW{1'b0}};

    fifo_sync_param_cfg_chk #(
        .DEPTH         (DEPTH),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_cfg_chk ();

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    wr_ptr_r;
    logic [CW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [AW-1:0]    wr_addr_s;
    logic [AW-1:0]    rd_addr_s;
    logic [WIDTH-1:0] head_s;
    logic             full_s;
    logic             empty_s;
    logic             rd_ok_s;
    logic             wr_acc_s;
    logic             rd_acc_s;
    logic             unused_ptr_msb_s;

    assign wr_addr_s        = wr_ptr_r[AW-1:0];
    assign rd_addr_s        = rd_ptr_r[AW-1:0];
    assign head_s           = mem_r[rd_addr_s];
    assign unused_ptr_msb_s = wr_ptr_r[AW] ^ rd_ptr_r[AW];

    // Flags come straight off the count register so they track it with no lag
    assign full_s         = (count_r == DEPTH_L);
    assign empty_s        = (count_r == ZERO_L);
    assign o_full         = full_s;
    assign o_empty        = empty_s;
    assign o_almost_full  = (count_r >= AFULL_L);
    assign o_almost_empty = (count_r <= AEMPTY_L);
    assign o_count        = count_r;

    // Full is judged on the pre-edge count, so a full FIFO rejects a write even when popped
    assign wr_acc_s = i_we && !full_s;
    assign rd_acc_s = i_re && rd_ok_s;

    // Storage write; no reset so it maps onto distributed RAM
    always_ff @(posedge i_clk) begin
        if (i_rst_n && wr_acc_s) begin
            mem_r[wr_addr_s] <= i_data;
        end
    end

    // Pointers and occupancy count
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_r <= ZERO_L;
            rd_ptr_r <= ZERO_L;
            count_r  <= ZERO_L;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_L;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_L;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + ONE_L;
                2'b01:   count_r <= count_r - ONE_L;
                default: count_r <= count_r;
            endcase
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word is presented combinationally; zero while empty so reset shows o_data = 0
        assign rd_ok_s = !empty_s;
        assign o_valid = !empty_s;
        assign o_data  = empty_s ? {WIDTH{1'b0}} : head_s;
    end else begin : g_std
        logic [WIDTH-1:0] data_r;
        logic             valid_r;

        assign rd_ok_s = !empty_s;

        // Registered read port: one-cycle valid pulse per accepted read, data held otherwise
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                data_r  <= {WIDTH{1'b0}};
                valid_r <= 1'b0;
            end else begin
                valid_r <= rd_acc_s;
                if (rd_acc_s) begin
                    data_r <= head_s;
                end
            end
        end

        assign o_data  = data_r;
        assign o_valid = valid_r;
    end

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_r;
    logic udf_r;

    // Sticky error flags; a set in the same cycle as a clear wins
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (i_we && full_s) begin
                ovf_r <= 1'b1;
            end else if (i_err_clr) begin
                ovf_r <= 1'b0;
            end else begin
                ovf_r <= ovf_r;
            end
            if (i_re && !rd_ok_s) begin
                udf_r <= 1'b1;
            end else if (i_err_clr) begin
                udf_r <= 1'b0;
            end else begin
                udf_r <= udf_r;
            end
        end
    end

    assign o_overflow  = ovf_r;
    assign o_underflow = udf_r;
`else
    logic unused_err_clr_s;

    assign unused_err_clr_s = i_err_clr;
    assign o_overflow       = 1'b0;
    assign o_underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-mode and an FWFT-mode instance.
module tb_fifo_sync_param;

`ifdef FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        s_we, s_re, s_clr;
    logic [31:0] s_din, s_dout;
    logic        s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [4:0]  s_count;
    logic        f_we, f_re, f_clr;
    logic [31:0] f_din, f_dout;
    logic        f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [4:0]  f_count;

    int n_chk;
    int n_fail;

    fifo_sync_param #(.WIDTH(32), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(0)) u_std (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(s_we), .i_data(s_din), .i_re(s_re),
        .i_err_clr(s_clr), .o_data(s_dout), .o_valid(s_valid), .o_full(s_full),
        .o_empty(s_empty), .o_almost_full(s_af), .o_almost_empty(s_ae),
        .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_udf)
    );

    fifo_sync_param #(.WIDTH(32), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .FWFT(1)) u_fwft (
        .i_clk(clk), .i_rst_n(rst_n), .i_we(f_we), .i_data(f_din), .i_re(f_re),
        .i_err_clr(f_clr), .o_data(f_dout), .o_valid(f_valid), .o_full(f_full),
        .o_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae),
        .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n, we, re, clr;
        logic [31:0] din;
        int          cnt;
        logic        emp, ful, af, ae, vld;
        logic [31:0] dout;
        logic        udf;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_std(input string t, input int cnt, input logic emp, input logic ful,
                           input logic af, input logic ae, input logic vld,
                           input logic [31:0] dout, input logic ovf, input logic udf);
        chk({t, ".count"}, 32'(s_count), 32'(cnt));
        chk({t, ".empty"}, 32'(s_empty), 32'(emp));
        chk({t, ".full"}, 32'(s_full), 32'(ful));
        chk({t, ".afull"}, 32'(s_af), 32'(af));
        chk({t, ".aempty"}, 32'(s_ae), 32'(ae));
        chk({t, ".valid"}, 32'(s_valid), 32'(vld));
        chk({t, ".data"}, s_dout, dout);
        chk({t, ".ovf"}, 32'(s_ovf), 32'(ovf & ERR_EN));
        chk({t, ".udf"}, 32'(s_udf), 32'(udf & ERR_EN));
    endtask

    task automatic chk_fw(input string t, input int cnt, input logic vld,
                          input logic [31:0] dout, input logic udf);
        chk({t, ".count"}, 32'(f_count), 32'(cnt));
        chk({t, ".empty"}, 32'(f_empty), 32'(cnt == 0));
        chk({t, ".valid"}, 32'(f_valid), 32'(vld));
        chk({t, ".data"}, f_dout, dout);
        chk({t, ".udf"}, 32'(f_udf), 32'(udf & ERR_EN));
        chk({t, ".ovf"}, 32'(f_ovf), 32'(1'b0));
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        rst_n = 1'b0;
        s_we = 1'b0; s_re = 1'b0; s_clr = 1'b0; s_din = 32'h0;
        f_we = 1'b0; f_re = 1'b0; f_clr = 1'b0; f_din = 32'h0;

        //               rst  we    re    clr   din       cnt emp   ful   af    ae    vld   dout      udf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h22, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h33, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h33, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h55, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h44, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h55, 1'b0};

        step(); step();
        chk_std("rst", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        chk_fw("fw_rst", 0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 15; i++) begin
            rst_n = vecs[i].rst_n; s_we = vecs[i].we; s_re = vecs[i].re;
            s_clr = vecs[i].clr; s_din = vecs[i].din;
            step();
            chk_std($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful,
                    vecs[i].af, vecs[i].ae, vecs[i].vld, vecs[i].dout, 1'b0, vecs[i].udf);
        end
        s_we = 1'b0; s_re = 1'b0; s_clr = 1'b0;

        // fill to full, watching the threshold flags
        for (int i = 0; i < 16; i++) begin
            s_we = 1'b1; s_din = 32'(i);
            step();
            chk_std($sformatf("fill%0d", i), i + 1, 1'b0, (i + 1) == 16, (i + 1) >= 14,
                    (i + 1) <= 2, 1'b0, 32'h55, 1'b0, 1'b0);
        end
        s_din = 32'hFF;
        step();
        chk_std("wr_full", 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h55, 1'b1, 1'b0);
        s_re = 1'b1; s_din = 32'hEE;
        step();
        chk_std("rw_full", 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0);
        s_we = 1'b0;
        for (int j = 1; j < 16; j++) begin
            step();
            chk_std($sformatf("drain%0d", j), 15 - j, (15 - j) == 0, 1'b0, (15 - j) >= 14,
                    (15 - j) <= 2, 1'b1, 32'(j), 1'b1, 1'b0);
        end
        s_re = 1'b0; s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        chk_std("ovf_clr", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hF, 1'b0, 1'b0);

        // reset mid-operation
        s_re = 1'b1;
        step();
        s_re = 1'b0;
        chk_std("udf_set", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hF, 1'b0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            s_we = 1'b1; s_din = 32'h70 + 32'(k);
            step();
        end
        chk_std("pre_rst", 7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hF, 1'b0, 1'b1);
        rst_n = 1'b0; s_din = 32'h99;
        step();
        chk_std("mid_rst", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b1; s_din = 32'hAB;
        step();
        s_we = 1'b0; s_re = 1'b1;
        chk_std("post_wr", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();
        s_re = 1'b0;
        chk_std("post_rd", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAB, 1'b0, 1'b0);
        step();
        chk_std("post_idle", 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hAB, 1'b0, 1'b0);

        // FWFT instance
        f_we = 1'b1; f_din = 32'hA5;
        step();
        f_we = 1'b0;
        chk_fw("fw_wr", 1, 1'b1, 32'hA5, 1'b0);
        step();
        chk_fw("fw_hold", 1, 1'b1, 32'hA5, 1'b0);
        f_re = 1'b1;
        step();
        chk_fw("fw_pop", 0, 1'b0, 32'h0, 1'b0);
        step();
        f_re = 1'b0;
        chk_fw("fw_udf", 0, 1'b0, 32'h0, 1'b1);
        f_clr = 1'b1;
        step();
        f_clr = 1'b0;
        chk_fw("fw_clr", 0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            f_we = 1'b1; f_din = 32'hC000 + 32'(k);
            step();
        end
        chk_fw("fw_pre", 3, 1'b1, 32'hC000, 1'b0);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("fw_head%0d", i), f_dout, 32'hC000 + 32'(i));
            f_we = 1'b1; f_re = 1'b1; f_din = 32'hC000 + 32'(i + 3);
            step();
        end
        f_we = 1'b0; f_re = 1'b0;
        chk_fw("fw_wrap", 3, 1'b1, 32'hC000 + 32'd40, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("fw_tail%0d", k), f_dout, 32'hC000 + 32'(40 + k));
            f_re = 1'b1;
            step();
        end
        f_re = 1'b0;
        chk_fw("fw_end", 0, 1'b0, 32'h0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
Parametrised synchronous single-clock FIFO, the next generation of the CPU's buffering FIFO, used between the UART/bus front-end and the core.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, and overflow/underflow protection.
- Adds a selectable first-word-fall-through (FWFT) read mode.
- Status flags reflect state in the same cycle as the state change, with no extra register lag.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- AFULL_THRESH, DEPTH-2, o_almost_full asserts when count >= AFULL_THRESH.
- AEMPTY_THRESH, 2, o_almost_empty asserts when count <= AEMPTY_THRESH.
- FWFT, 0, read mode: 0 = standard (1-cycle read latency), 1 = first-word-fall-through.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_we  in  1  write request.
- i_data  in  WIDTH  write data.
- i_re  in  1  read request (FWFT: pop/acknowledge).
- i_err_clr  in  1  clears sticky error flags.
- o_data  out  WIDTH  read data.
- o_valid  out  1  o_data holds a valid word.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_almost_full  out  1  count >= AFULL_THRESH.
- o_almost_empty  out  1  count <= AEMPTY_THRESH.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky: write attempted while full.
- o_underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Reset: synchronous, active-low. i_rst_n=0 at a rising edge has priority over every other input and takes effect at that edge. Reset mid-operation discards all contents.
  - Pointers = 0, count = 0, o_data = 0, o_valid = 0.
  - o_empty = 1, o_almost_empty = 1, o_full = 0, o_almost_full = 0.
  - o_overflow = 0, o_underflow = 0.
- Storage: DEPTH x WIDTH distributed RAM. Read/write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; address = low bits.
- Count is an explicit register updated each cycle:
  - +1 on an accepted write only.
  - -1 on an accepted read only.
  - Unchanged when both or neither are accepted.
- All status outputs are combinational from the count register, so they are valid the cycle after the causing edge.
- Write accepted iff i_we && !o_full. A rejected write does not change memory or pointers.
- Read accepted iff i_re && !o_empty (standard mode) or i_re && o_valid (FWFT mode).
- Simultaneous accepted read and write:
  - Both pointers advance; count unchanged.
  - When full: the read is accepted and the write is rejected; full is evaluated before this cycle's read.
  - When empty: the write is accepted and the read is rejected.
- Standard mode (FWFT=0):
  - On an accepted read, o_data <= mem[rd_addr] at the edge and o_valid = 1 for exactly the following cycle.
  - Otherwise o_valid = 0, and o_data holds its last value.
- FWFT mode (FWFT=1):
  - o_valid = !o_empty.
  - o_data = mem[rd_addr] combinationally (head word), available the cycle after it is written.
  - i_re with o_valid pops the head.
- Wrap-around: after DEPTH writes and DEPTH reads, pointers return to the same address and ordering is preserved indefinitely.
- Thresholds outside 0..DEPTH are a configuration error; they are flagged by an elaboration-time check.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - o_overflow sets on i_we && o_full.
  - o_underflow sets on i_re && o_empty (standard mode) or i_re && !o_valid (FWFT mode).
  - Both flags are sticky until i_err_clr=1 or reset. If set and clear occur in the same cycle, set wins.
- Undefined: o_overflow and o_underflow are tied to 0 and i_err_clr is ignored; the port list is unchanged.

Test Plan:
- Reset, then write 0x11,0x22,0x33 (DEPTH=16, FWFT=0), then read 3 -> o_data 0x11,0x22,0x33, each with a 1-cycle o_valid pulse one cycle after the read; o_count 3->0; o_empty=1 at end.
- Write 16 words 0..15 -> o_full=1 and o_count=16; 17th write of 0xFF rejected; drain returns 0..15 with no 0xFF; o_overflow=1 if FIFO_ERR_FLAGS_EN is defined.
- Thresholds AFULL_THRESH=14, AEMPTY_THRESH=2: o_almost_empty drops on the 3rd write (count 3); o_almost_full rises on the 14th write (count 14).
- Full FIFO with i_we=i_re=1 for 1 cycle -> read accepted, write rejected, o_count=15; empty FIFO with both high -> write accepted, o_count=1, o_valid=0.
- FWFT=1: write 0xA5 -> next cycle o_valid=1, o_data=0xA5 with no i_re; pulse i_re -> o_valid=0; 40 write/read pairs (wrap) return data in order.
- Assert i_rst_n=0 for 1 cycle with count=7 -> next cycle o_count=0, o_empty=1, o_valid=0, error flags 0; a subsequent write/read returns the new data only.
